// File: rtl/connect4_pkg.sv
// Shared Connect Four encodings, board geometry defaults and sequencer states.
// No logic; used by move_sequencer, board_clearer and victory_checker.
// No flow control.
package connect4_pkg;

    localparam int C4_NUM_ROWS = 6;
    localparam int C4_NUM_COLS = 7;

    localparam logic [1:0] PIECE_EMPTY = 2'b00;
    localparam logic [1:0] PIECE_P1    = 2'b01;
    localparam logic [1:0] PIECE_P2    = 2'b10;

    localparam logic [1:0] RESULT_NONE = 2'b00;
    localparam logic [1:0] RESULT_P1   = 2'b01;
    localparam logic [1:0] RESULT_P2   = 2'b10;
    localparam logic [1:0] RESULT_DRAW = 2'b11;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_SCAN,
        ST_WRITE,
        ST_VC_START,
        ST_VC_WAIT,
        ST_RESOLVE,
        ST_OVER
    } seq_state_t;

    function automatic logic [1:0] other_player(input logic [1:0] p);
        return (p == PIECE_P1) ? PIECE_P2 : PIECE_P1;
    endfunction

endpackage

// File: rtl/board_clearer.sv
// Column-major cell address walker used while wiping the board.
// Advances one cell per enabled cycle; done flags the last cell.
// No backpressure: the caller gates progress with en.
module board_clearer
    import connect4_pkg::*;
#(
    parameter int NUM_ROWS = C4_NUM_ROWS,
    parameter int NUM_COLS = C4_NUM_COLS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       done
);

    localparam logic [2:0] LAST_ROW = 3'(NUM_ROWS - 1);
    localparam logic [2:0] LAST_COL = 3'(NUM_COLS - 1);

    assign done = (row == LAST_ROW) && (col == LAST_COL);

    // Wraps to cell 0 after the last cell so the next clear starts clean.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (done) begin
                row <= '0;
                col <= '0;
            end else if (row == LAST_ROW) begin
                row <= '0;
                col <= col + 3'd1;
            end else begin
                row <= row + 3'd1;
            end
        end
    end

endmodule

// File: rtl/move_sequencer.sv
// Connect Four turn controller: clear, column scan, piece write, win check, resolve. MOVE_TIMER_EN adds a move-timeout forfeit.
// Latency: accept to vc_start is 3 cycles plus one per piece already in the column; clear takes NUM_ROWS*NUM_COLS cycles.
// Backpressure: move_ready is high only in ST_IDLE; new_game is deferred while victory_checker runs.
module move_sequencer
    import connect4_pkg::*;
#(
    parameter int NUM_ROWS       = C4_NUM_ROWS,
    parameter int NUM_COLS       = C4_NUM_COLS,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [2:0] move_col,
    output logic       move_ready,
    output logic       illegal_move,
    output logic [2:0] brd_read_row,
    output logic [2:0] brd_read_col,
    input  logic [1:0] brd_data_in,
    output logic       brd_we,
    output logic [2:0] brd_write_row,
    output logic [2:0] brd_write_col,
    output logic [1:0] brd_write_data,
    output logic       vc_start,
    output logic [2:0] vc_move_row,
    output logic [2:0] vc_move_col,
    input  logic [2:0] vc_read_row,
    input  logic [2:0] vc_read_col,
    input  logic       vc_done,
    input  logic [1:0] vc_winner,
    output logic [1:0] current_player,
    output logic       game_over,
    output logic [1:0] result,
    output logic [5:0] move_count
);

    localparam logic [2:0] LAST_ROW   = 3'(NUM_ROWS - 1);
    localparam logic [3:0] NUM_COLS_W = 4'(NUM_COLS);
    localparam logic [5:0] NUM_CELLS  = 6'(NUM_ROWS * NUM_COLS);

    seq_state_t state_q, state_d;

    logic [2:0] col_q, row_q, vc_row_q, vc_col_q;
    logic [1:0] player_q, result_q, winner_q, result_d;
    logic [5:0] count_q;
    logic       game_over_q, illegal_q, ng_pend_q;
    logic       ng_pend_d, illegal_d, take_move, scan_inc, finish, toggle;
    logic       timeout;
    logic [2:0] clr_row, clr_col;
    logic       clr_done, vc_sel;

    board_clearer #(
        .NUM_ROWS (NUM_ROWS),
        .NUM_COLS (NUM_COLS)
    ) u_clearer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == ST_CLEAR),
        .row   (clr_row),
        .col   (clr_col),
        .done  (clr_done)
    );

`ifdef MOVE_TIMER_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    logic [TMR_W-1:0] timer_q;

    // Any move request in IDLE is either accepted or rejected, so it restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if (state_q == ST_IDLE && !move_valid && !new_game) begin
            timer_q <= timer_q + TMR_W'(1);
        end else begin
            timer_q <= '0;
        end
    end

    assign timeout = (state_q == ST_IDLE) && (timer_q == TMR_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        take_move = 1'b0;
        scan_inc  = 1'b0;
        finish    = 1'b0;
        toggle    = 1'b0;
        result_d  = result_q;
        ng_pend_d = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (clr_done) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (new_game) begin
                    state_d = ST_CLEAR;
                end else if (move_valid) begin
                    if ({1'b0, move_col} >= NUM_COLS_W) begin
                        illegal_d = 1'b1;
                    end else begin
                        take_move = 1'b1;
                        state_d   = ST_SCAN;
                    end
                end else if (timeout) begin
                    finish   = 1'b1;
                    result_d = other_player(player_q);
                    state_d  = ST_OVER;
                end
            end
            ST_SCAN: begin
                if (new_game) begin
                    state_d = ST_CLEAR;
                end else if (brd_data_in == PIECE_EMPTY) begin
                    state_d = ST_WRITE;
                end else if (row_q == LAST_ROW) begin
                    illegal_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    scan_inc = 1'b1;
                end
            end
            ST_WRITE:    state_d = new_game ? ST_CLEAR : ST_VC_START;
            ST_VC_START: state_d = new_game ? ST_CLEAR : ST_VC_WAIT;
            ST_VC_WAIT: begin
                // The checker owns the read port here, so a clear must wait for it.
                if (vc_done) begin
                    state_d = (ng_pend_q || new_game) ? ST_CLEAR : ST_RESOLVE;
                end else begin
                    ng_pend_d = ng_pend_q | new_game;
                end
            end
            ST_RESOLVE: begin
                if (new_game) begin
                    state_d = ST_CLEAR;
                end else if (winner_q != RESULT_NONE) begin
                    finish   = 1'b1;
                    result_d = winner_q;
                    state_d  = ST_OVER;
                end else if (count_q == NUM_CELLS) begin
                    finish   = 1'b1;
                    result_d = RESULT_DRAW;
                    state_d  = ST_OVER;
                end else begin
                    toggle  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_OVER: begin
                if (new_game) state_d = ST_CLEAR;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            col_q       <= '0;
            row_q       <= '0;
            vc_row_q    <= '0;
            vc_col_q    <= '0;
            player_q    <= PIECE_P1;
            result_q    <= RESULT_NONE;
            winner_q    <= RESULT_NONE;
            count_q     <= '0;
            game_over_q <= 1'b0;
            illegal_q   <= 1'b0;
            ng_pend_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            ng_pend_q <= ng_pend_d;
            if (take_move) begin
                col_q <= move_col;
                row_q <= '0;
            end
            if (scan_inc) row_q <= row_q + 3'd1;
            if (state_q == ST_WRITE) begin
                count_q  <= count_q + 6'd1;
                vc_row_q <= row_q;
                vc_col_q <= col_q;
            end
            if (state_q == ST_VC_WAIT && vc_done) winner_q <= vc_winner;
            if (state_q == ST_CLEAR && clr_done) begin
                player_q    <= PIECE_P1;
                count_q     <= '0;
                result_q    <= RESULT_NONE;
                game_over_q <= 1'b0;
            end
            if (finish) begin
                result_q    <= result_d;
                game_over_q <= 1'b1;
            end
            if (toggle) player_q <= other_player(player_q);
        end
    end

    assign vc_sel         = (state_q == ST_VC_START) || (state_q == ST_VC_WAIT);
    assign brd_read_row   = vc_sel ? vc_read_row : row_q;
    assign brd_read_col   = vc_sel ? vc_read_col : col_q;

    // Gated by rst_n so the reset-time ST_CLEAR does not strobe a write.
    assign brd_we         = rst_n && ((state_q == ST_CLEAR) || (state_q == ST_WRITE));
    assign brd_write_row  = (state_q == ST_CLEAR) ? clr_row : row_q;
    assign brd_write_col  = (state_q == ST_CLEAR) ? clr_col : col_q;
    assign brd_write_data = (state_q == ST_CLEAR) ? PIECE_EMPTY : player_q;

    assign move_ready     = (state_q == ST_IDLE);
    assign illegal_move   = illegal_q;
    assign vc_start       = (state_q == ST_VC_START);
    assign vc_move_row    = vc_row_q;
    assign vc_move_col    = vc_col_q;
    assign current_player = player_q;
    assign game_over      = game_over_q;
    assign result         = result_q;
    assign move_count     = count_q;

endmodule
